pkt_merger: RTL and testbench

Merges the data-path AXI-Stream from the match-action pipeline with control-response packets from the control path into one egress AXI-Stream. Control packets arrive without back-pressure and are stored-and-forwarded through an internal commit-on-tlast FIFO. Arbitration is packet-atomic. The block sits at the pipeline tail, mirroring the ingress filter that splits control traffic off.

---
 rtl/pkt_merger_if.sv | 17 +
 rtl/pkt_merger.sv | 185 ++++++++++++++++++
 tb/tb_pkt_merger.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_merger_if.sv
// AXI-Stream bundle shared by the pkt_merger ports. The control input has no
// back-pressure, so it uses the slave_nobp view, which leaves tready out.
interface pkt_merger_if #(
  parameter int DW = 256,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
  modport slave_nobp (input tdata, tkeep, tuser, tvalid, tlast);
endinterface

// File: rtl/pkt_merger.sv
// Merges the data-path stream with store-and-forward control packets into one
// egress stream, packet-atomic. Define PKT_MERGER_RR_EN for round-robin arbitration.
module pkt_merger #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CTRL_FIFO_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  pkt_merger_if.slave      s_axis,
  pkt_merger_if.slave_nobp ctrl_s_axis,
  pkt_merger_if.master     m_axis,
  output logic [31:0]      ctrl_drop_cnt
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int KW    = DW / 8;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int DB    = CTRL_FIFO_DEPTH_BITS;
  localparam int PTRW  = DB + 1;
  localparam int DEPTH = 1 << DB;
  localparam int FW    = DW + KW + UW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_CTRL = 2'd2;

  logic [FW-1:0]   r_mem [DEPTH];
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_wr_commit;
  logic [PTRW-1:0] r_rd_ptr;
  logic [PTRW-1:0] r_pkt_cnt;
  logic            r_drop;
  logic [31:0]     r_drop_cnt;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;

  logic            w_full;
  logic            w_wr_en;
  logic            w_commit;
  logic [FW-1:0]   w_head;
  logic            w_rd_en;
  logic            w_pkt_done;
  logic            w_ctrl_pend;
  logic            w_pick_ctrl;

  // Full is judged against the read pointer before this cycle's read moves it.
  assign w_full      = (r_wr_ptr - r_rd_ptr) == PTRW'(DEPTH);
  assign w_wr_en     = ctrl_s_axis.tvalid && !r_drop && !w_full;
  assign w_commit    = w_wr_en && ctrl_s_axis.tlast;
  assign w_head      = r_mem[r_rd_ptr[DB-1:0]];
  assign w_rd_en     = (r_state == ST_CTRL) && m_axis.tready && (r_rd_ptr != r_wr_commit);
  assign w_pkt_done  = w_rd_en && w_head[0];
  assign w_ctrl_pend = (r_pkt_cnt != '0);

  assign ctrl_drop_cnt = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[DB-1:0]] <= {ctrl_s_axis.tdata, ctrl_s_axis.tkeep,
                                  ctrl_s_axis.tuser, ctrl_s_axis.tlast};
    end
  end

  // An overflowing packet rolls the write pointer back to the last commit and
  // swallows the rest of that packet; the drop is counted on its tlast.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_drop      <= 1'b0;
      r_drop_cnt  <= '0;
    end else if (ctrl_s_axis.tvalid) begin
      if (r_drop) begin
        if (ctrl_s_axis.tlast) begin
          r_drop     <= 1'b0;
          r_drop_cnt <= r_drop_cnt + 32'd1;
        end
      end else if (w_full) begin
        r_wr_ptr <= r_wr_commit;
        if (ctrl_s_axis.tlast) begin
          r_drop_cnt <= r_drop_cnt + 32'd1;
        end else begin
          r_drop <= 1'b1;
        end
      end else begin
        r_wr_ptr <= r_wr_ptr + PTRW'(1);
        if (ctrl_s_axis.tlast) begin
          r_wr_commit <= r_wr_ptr + PTRW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_ptr  <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTRW'(1);
      end
      case ({w_commit, w_pkt_done})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + PTRW'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - PTRW'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

`ifdef PKT_MERGER_RR_EN
  logic r_last_grant;

  assign w_pick_ctrl = w_ctrl_pend && (!s_axis.tvalid || !r_last_grant);

  // Remembers who won the last IDLE exit: 1 = control, 0 = data.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_last_grant <= 1'b0;
    end else if ((r_state == ST_IDLE) && (w_state_nxt != ST_IDLE)) begin
      r_last_grant <= (w_state_nxt == ST_CTRL);
    end
  end
`else
  assign w_pick_ctrl = w_ctrl_pend;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_ctrl) begin
          w_state_nxt = ST_CTRL;
        end else if (s_axis.tvalid) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CTRL: begin
        if (w_pkt_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Egress mux: the inactive source never leaks onto m_axis.
  always_comb begin
    m_axis.tdata  = '0;
    m_axis.tkeep  = '0;
    m_axis.tuser  = '0;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    s_axis.tready = 1'b0;
    case (r_state)
      ST_DATA: begin
        m_axis.tdata  = s_axis.tdata;
        m_axis.tkeep  = s_axis.tkeep;
        m_axis.tuser  = s_axis.tuser;
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tlast  = s_axis.tlast;
        s_axis.tready = m_axis.tready;
      end
      ST_CTRL: begin
        {m_axis.tdata, m_axis.tkeep, m_axis.tuser, m_axis.tlast} = w_head;
        m_axis.tvalid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pkt_merger.sv
// Testbench for pkt_merger: cycle table for the data path, scoreboard of expected
// egress beats, and hand-written control, overflow, contention and reset sequences.
module tb_pkt_merger;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] ctrl_drop_cnt;

  pkt_merger_if #(.DW(DW), .UW(UW)) s_if ();
  pkt_merger_if #(.DW(DW), .UW(UW)) c_if ();
  pkt_merger_if #(.DW(DW), .UW(UW)) m_if ();

  pkt_merger dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis        (s_if),
    .ctrl_s_axis   (c_if),
    .m_axis        (m_if),
    .ctrl_drop_cnt (ctrl_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    logic        sv;
    logic [31:0] d;
    logic        l;
    logic        rdy;
    logic        emv;
    logic        estr;
    logic [31:0] ed;
  } vec_t;

  beat_t qExp[$];
  beat_t monBeat;
  vec_t  vecs[10];
  int    numChecks = 0;
  int    numErrors = 0;
  logic  stallPrev = 1'b0;
  logic [DW-1:0] heldData;
  logic  dataDone;

  function automatic logic [DW-1:0] mkData(input logic [31:0] v);
    return {8{v}};
  endfunction

  function automatic logic [KW-1:0] mkKeep(input logic l);
    return l ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [UW-1:0] mkUser(input logic [31:0] v);
    return {4{v ^ 32'h5A5A_0000}};
  endfunction

  function automatic beat_t mkBeat(input logic [31:0] v, input logic l);
    beat_t b;
    b.d = mkData(v);
    b.k = mkKeep(l);
    b.u = mkUser(v);
    b.l = l;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    numChecks++;
    if (act !== exp) begin
      numErrors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    s_if.tvalid = v.sv;
    s_if.tdata  = mkData(v.d);
    s_if.tkeep  = mkKeep(v.l);
    s_if.tuser  = mkUser(v.d);
    s_if.tlast  = v.l;
    m_if.tready = v.rdy;
  endtask

  task automatic pushPkt(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) qExp.push_back(mkBeat(32'(base + 32'(i)), i == n - 1));
  endtask

  task automatic sendCtrl(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      c_if.tvalid = 1'b1;
      c_if.tdata  = mkData(32'(base + 32'(i)));
      c_if.tkeep  = mkKeep(i == n - 1);
      c_if.tuser  = mkUser(32'(base + 32'(i)));
      c_if.tlast  = (i == n - 1);
      @(posedge clk); #1;
    end
    c_if.tvalid = 1'b0;
    c_if.tlast  = 1'b0;
  endtask

  task automatic sendData(input int n, input logic [31:0] base);
    int cnt;
    for (int i = 0; i < n; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = mkData(32'(base + 32'(i)));
      s_if.tkeep  = mkKeep(i == n - 1);
      s_if.tuser  = mkUser(32'(base + 32'(i)));
      s_if.tlast  = (i == n - 1);
      cnt = 0;
      @(negedge clk);
      while (!s_if.tready && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      if (!s_if.tready) begin
        numChecks++;
        numErrors++;
        $display("[TB] FAIL data_handshake: got tready=0 expected tready=1 within 200 cycles");
      end
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (qExp.size() != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_queue", DW'(qExp.size()), DW'(0));
    @(posedge clk); #1;
  endtask

  // Egress monitor: pops the scoreboard on every accepted beat and verifies
  // that a stalled beat stays valid and unchanged.
  always @(negedge clk) begin
    if (!aresetn) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("hold_tvalid", DW'(m_if.tvalid), DW'(1));
        checkOutput("hold_tdata", m_if.tdata, heldData);
      end
      if (m_if.tvalid && m_if.tready) begin
        if (qExp.size() == 0) begin
          numChecks++;
          numErrors++;
          $display("[TB] FAIL sb_unexpected: got %h expected no beat", m_if.tdata);
        end else begin
          monBeat = qExp.pop_front();
          checkOutput("sb_tdata", m_if.tdata, monBeat.d);
          checkOutput("sb_tkeep", DW'(m_if.tkeep), DW'(monBeat.k));
          checkOutput("sb_tuser", DW'(m_if.tuser), DW'(monBeat.u));
          checkOutput("sb_tlast", DW'(m_if.tlast), DW'(monBeat.l));
        end
      end
      stallPrev = m_if.tvalid && !m_if.tready;
      heldData  = m_if.tdata;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h1000_00D0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h1000_00D0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_00D0};
    vecs[2] = '{1'b1, 32'h1000_00D1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_00D1};
    vecs[3] = '{1'b1, 32'h1000_00D2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1000_00D2};
    vecs[4] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h1000_00D3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 32'h1000_00D3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_00D3};
    vecs[8] = '{1'b1, 32'h1000_00D3, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1000_00D3};
    vecs[9] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    c_if.tvalid = 1'b0; c_if.tdata = '0; c_if.tkeep = '0; c_if.tuser = '0; c_if.tlast = 1'b0;
    m_if.tready = 1'b1;

    // Reset state
    #2;
    checkOutput("rst_m_tvalid", DW'(m_if.tvalid), DW'(0));
    checkOutput("rst_m_tlast", DW'(m_if.tlast), DW'(0));
    checkOutput("rst_m_tdata", m_if.tdata, DW'(0));
    checkOutput("rst_s_tready", DW'(s_if.tready), DW'(0));
    checkOutput("rst_drop_cnt", DW'(ctrl_drop_cnt), DW'(0));
    @(posedge clk); @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] data path table");
    pushPkt(3, 32'h1000_00D0);
    pushPkt(1, 32'h1000_00D3);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_m_tvalid", i), DW'(m_if.tvalid), DW'(vecs[i].emv));
      checkOutput($sformatf("vec%0d_s_tready", i), DW'(s_if.tready), DW'(vecs[i].estr));
      checkOutput($sformatf("vec%0d_m_tdata", i), m_if.tdata, vecs[i].emv ? mkData(vecs[i].ed) : DW'(0));
      checkOutput($sformatf("vec%0d_m_tlast", i), DW'(m_if.tlast), DW'(vecs[i].emv & vecs[i].l));
      @(posedge clk); #1;
    end
    waitDrain(20);

    $display("[TB] control only");
    m_if.tready = 1'b1;
    pushPkt(2, 32'h0000_00A1);
    sendCtrl(2, 32'h0000_00A1);
    @(negedge clk);
    checkOutput("ctrl_lat_t1_tvalid", DW'(m_if.tvalid), DW'(0));
    @(negedge clk);
    checkOutput("ctrl_lat_t2_tvalid", DW'(m_if.tvalid), DW'(1));
    checkOutput("ctrl_lat_t2_tdata", m_if.tdata, mkData(32'h0000_00A1));
    @(posedge clk); #1;
    waitDrain(20);
    checkOutput("ctrl_drop_cnt", DW'(ctrl_drop_cnt), DW'(0));

    $display("[TB] back-pressure");
    m_if.tready = 1'b1;
    dataDone = 1'b0;
    pushPkt(4, 32'h2000_00B0);
    fork
      begin
        sendData(4, 32'h2000_00B0);
        dataDone = 1'b1;
      end
      begin
        int k = 0;
        while (!dataDone && k < 200) begin
          @(posedge clk); #1;
          if (!dataDone) m_if.tready = ~m_if.tready;
          k++;
        end
      end
    join
    m_if.tready = 1'b1;
    waitDrain(20);

    $display("[TB] contention");
    m_if.tready = 1'b0;
    sendCtrl(2, 32'h3000_0C10);
    sendCtrl(2, 32'h3000_0C20);
`ifdef PKT_MERGER_RR_EN
    pushPkt(2, 32'h3000_0C10);
    pushPkt(2, 32'h4000_0DA0);
    pushPkt(2, 32'h3000_0C20);
    pushPkt(2, 32'h4000_0DB0);
`else
    pushPkt(2, 32'h3000_0C10);
    pushPkt(2, 32'h3000_0C20);
    pushPkt(2, 32'h4000_0DA0);
    pushPkt(2, 32'h4000_0DB0);
`endif
    fork
      begin
        sendData(2, 32'h4000_0DA0);
        sendData(2, 32'h4000_0DB0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_if.tready = 1'b1;
      end
    join
    waitDrain(50);

    $display("[TB] overflow");
    m_if.tready = 1'b0;
    sendCtrl(10, 32'h5000_0E00);
    sendCtrl(10, 32'h6000_0F00);
    @(negedge clk);
    checkOutput("ovf_drop_cnt", DW'(ctrl_drop_cnt), DW'(1));
    checkOutput("ovf_pkt_cnt_held", DW'(dut.r_pkt_cnt), DW'(1));
    @(posedge clk); #1;
    pushPkt(10, 32'h5000_0E00);
    m_if.tready = 1'b1;
    waitDrain(40);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("ovf_pkt_cnt_end", DW'(dut.r_pkt_cnt), DW'(0));
    checkOutput("ovf_idle_tvalid", DW'(m_if.tvalid), DW'(0));
    @(posedge clk); #1;

    $display("[TB] reset mid packet");
    m_if.tready = 1'b0;
    sendCtrl(4, 32'h7000_0000);
    for (int i = 0; i < 3; i++) begin
      c_if.tvalid = 1'b1;
      c_if.tdata  = mkData(32'h7100_0000 + 32'(i));
      c_if.tkeep  = mkKeep(1'b0);
      c_if.tuser  = mkUser(32'h7100_0000 + 32'(i));
      c_if.tlast  = 1'b0;
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    #2 aresetn = 1'b0;
    #1;
    checkOutput("rstmid_m_tvalid", DW'(m_if.tvalid), DW'(0));
    checkOutput("rstmid_m_tdata", m_if.tdata, DW'(0));
    checkOutput("rstmid_m_tkeep", DW'(m_if.tkeep), DW'(0));
    checkOutput("rstmid_m_tuser", DW'(m_if.tuser), DW'(0));
    checkOutput("rstmid_m_tlast", DW'(m_if.tlast), DW'(0));
    checkOutput("rstmid_s_tready", DW'(s_if.tready), DW'(0));
    checkOutput("rstmid_drop_cnt", DW'(ctrl_drop_cnt), DW'(0));
    checkOutput("rstmid_pkt_cnt", DW'(dut.r_pkt_cnt), DW'(0));
    c_if.tvalid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    aresetn = 1'b1;
    m_if.tready = 1'b1;
    @(posedge clk); #1;
    pushPkt(2, 32'h8000_0000);
    sendCtrl(2, 32'h8000_0000);
    waitDrain(20);
    checkOutput("post_rst_drop_cnt", DW'(ctrl_drop_cnt), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
